// File: rtl/seq_binary_divider.sv
// seq_binary_divider: restoring unsigned divider, one quotient bit per clock,
// with a start/busy/done handshake and divide-by-zero flag.
module seq_binary_divider #(
    parameter int DIVIDEND_W = 4,
    parameter int DIVISOR_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);
    localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVISOR_W-1:0]  prem_q, prem_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W-1:0]  diff;
    logic                  fits;
    logic                  last;

    // The stored remainder is always below the divisor, so only the shifted
    // trial value needs the extra bit; the difference then fits in DIVISOR_W.
    assign trial = {prem_q, dvd_q[DIVIDEND_W-1]};
    assign fits  = trial >= {1'b0, dvs_q};
    assign diff  = trial[DIVISOR_W-1:0] - dvs_q;
    assign last  = cnt_q == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = state_q != IDLE;
        done = state_q == DONE;
    end

    // A zero divisor takes a single RUN cycle (counter starts at 0) so its
    // done pulse lands one edge after acceptance.
    always_comb begin
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        quot_d      = quot_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        if (state_q == IDLE && start) begin
            dvd_d  = dividend;
            dvs_d  = divisor;
            prem_d = '0;
            quot_d = '0;
            dbz_d  = 1'b0;
            cnt_d  = (divisor == '0) ? '0 : CW'(DIVIDEND_W - 1);
        end else if (state_q == RUN) begin
            dvd_d  = dvd_q << 1;
            prem_d = fits ? diff : trial[DIVISOR_W-1:0];
            quot_d = (quot_q << 1) | DIVIDEND_W'(fits);
            cnt_d  = cnt_q - 1'b1;
            if (last) begin
                quotient_d  = (dvs_q == '0) ? '1 : quot_d;
                remainder_d = (dvs_q == '0) ? '0 : prem_d;
                dbz_d       = dvs_q == '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            quot_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            quot_q      <= quot_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_binary_divider.sv
// tb_seq_binary_divider: vector table, random pairs against an arithmetic
// model, back-to-back issue with start held high, and async reset mid-run.
module tb_seq_binary_divider;
    localparam int DW = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [SW-1:0] divisor = '0;
    logic          busy, done, div_by_zero;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;

    typedef struct {
        logic [DW-1:0] a;
        logic [SW-1:0] b;
        logic [DW-1:0] q;
        logic [SW-1:0] r;
        logic          z;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail = 0;

    seq_binary_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic vec_t model(input logic [DW-1:0] a, input logic [SW-1:0] b);
        vec_t v;
        v.a = a;
        v.b = b;
        v.z = (b == 0);
        v.q = (b == 0) ? DW'(2 ** DW - 1) : DW'(int'(a) / int'(b));
        v.r = (b == 0) ? SW'(0) : SW'(int'(a) % int'(b));
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Entered and left at posedge+1 with the DUT idle.
    task automatic run_div(input vec_t v);
        int n = 0;
        int bc;
        int lat = (v.b == 0) ? 1 : DW;
        logic seen = 1'b0;
        dividend = v.a;
        divisor = v.b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = DW'($urandom);
        divisor = SW'($urandom);
        bc = int'(busy);
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            bc += int'(busy);
            seen = done;
            dividend = DW'($urandom);
            divisor = SW'($urandom);
        end
        chk($sformatf("latency %0d/%0d", v.a, v.b), n, lat);
        chk($sformatf("busy_cycles %0d/%0d", v.a, v.b), bc, lat + 1);
        chk($sformatf("quotient %0d/%0d", v.a, v.b), int'(quotient), int'(v.q));
        chk($sformatf("remainder %0d/%0d", v.a, v.b), int'(remainder), int'(v.r));
        chk($sformatf("div_by_zero %0d/%0d", v.a, v.b), int'(div_by_zero), int'(v.z));
        @(posedge clk); #1;
        chk("done_falls", int'(done), 0);
        chk("busy_falls", int'(busy), 0);
        chk("quotient_stable", int'(quotient), int'(v.q));
    endtask

    initial begin
        vec_t ops[3];
        int dones;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        vecs.push_back('{4'd15, 2'd3, 4'd5, 2'd0, 1'b0});
        vecs.push_back('{4'd13, 2'd2, 4'd6, 2'd1, 1'b0});
        vecs.push_back('{4'd2, 2'd3, 4'd0, 2'd2, 1'b0});
        vecs.push_back('{4'd9, 2'd0, 4'd15, 2'd0, 1'b1});
        vecs.push_back('{4'd6, 2'd2, 4'd3, 2'd0, 1'b0});
        for (int a = 0; a < 4; a++)
            for (int b = 1; b < 4; b++)
                vecs.push_back('{DW'(a * b), SW'(b), DW'(a), SW'(0), 1'b0});
        for (int i = 0; i < 10; i++)
            vecs.push_back(model(DW'($urandom), SW'($urandom)));
        foreach (vecs[i]) run_div(vecs[i]);

        // start held high: only operands present at accepting edges count
        for (int k = 0; k < 3; k++) ops[k] = model(DW'($urandom), SW'($urandom_range(3, 1)));
        dones = 0;
        dividend = ops[0].a;
        divisor = ops[0].b;
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            dividend = DW'($urandom);
            divisor = SW'($urandom);
            for (int i = 1; i <= 5; i++) begin
                @(posedge clk); #1;
                dones += int'(done);
                if (i == DW) begin
                    chk($sformatf("hold_q%0d", k), int'(quotient), int'(ops[k].q));
                    chk($sformatf("hold_r%0d", k), int'(remainder), int'(ops[k].r));
                end
                if (i < 5) begin
                    dividend = DW'($urandom);
                    divisor = SW'($urandom);
                end else if (k < 2) begin
                    dividend = ops[k+1].a;
                    divisor = ops[k+1].b;
                end
            end
        end
        start = 1'b0;
        chk("hold_done_count", dones, 3);

        // async reset mid-run
        dividend = 4'd12;
        divisor = 2'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_quotient", int'(quotient), 0);
        chk("arst_remainder", int'(remainder), 0);
        chk("arst_dbz", int'(div_by_zero), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            dones += int'(done) + int'(busy);
        end
        chk("arst_no_done", dones, 0);
        run_div('{4'd12, 2'd3, 4'd4, 2'd0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
